// File: rtl/timing_sequencer.sv
// ---------------------------------------------------------------------------
// timing_sequencer
//   Sequence counter / timing controller for the control unit. Produces the
//   3-bit timing count that selects the T-state decoder, the gated one-hot
//   T0..T7 vector, a one-cycle instruction-retired pulse and a retired
//   instruction counter. Supports start/halt, early end-of-instruction clear
//   (sc_clr) and memory wait stalls (mem_wait).
//
//   Build option: define SINGLE_STEP_EN to add the `step` input. A step
//   pulse in IDLE runs exactly one instruction and then returns to IDLE.
// ---------------------------------------------------------------------------
module timing_sequencer #(
   parameter int unsigned T_LAST = 7,   // last legal timing state (1..7)
   parameter int unsigned CNT_W  = 16   // width of instr_cnt
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   input  logic             sc_clr,
   input  logic             mem_wait,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [2:0]       tcounts,
   output logic [7:0]       T,
   output logic             running,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [2:0] T_LAST_C = 3'(T_LAST);

   state_t     state, state_nxt;
   logic [2:0] tcounts_nxt;
   logic       halt_pend, halt_pend_nxt;
   logic       retire;

   // Next-state logic: launch from IDLE, advance/stall/retire in RUN, hold in WAIT.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_nxt     = state;
      tcounts_nxt   = tcounts;
      halt_pend_nxt = halt_pend;
      retire        = 1'b0;

      unique case (state)
         IDLE: begin
            tcounts_nxt = 3'd0;
            if (start) begin
               // start wins over a same-cycle halt_req, which then becomes a
               // pending halt so exactly one instruction executes.
               state_nxt     = RUN;
               halt_pend_nxt = halt_req;
            end
`ifdef SINGLE_STEP_EN
            else if (step) begin
               state_nxt     = RUN;
               halt_pend_nxt = 1'b1;
            end
`endif
         end

         RUN: begin
            if (halt_req) halt_pend_nxt = 1'b1;

            if (sc_clr)                   retire      = 1'b1;
            else if (mem_wait)            state_nxt   = WAIT;
            else if (tcounts == T_LAST_C) retire      = 1'b1;
            else                          tcounts_nxt = tcounts + 3'd1;

            if (retire) begin
               tcounts_nxt = 3'd0;
               // A halt requested on the retire edge itself takes effect now.
               if (halt_pend || halt_req) begin
                  state_nxt     = IDLE;
                  halt_pend_nxt = 1'b0;
               end
            end
         end

         WAIT: begin
            // Count frozen and sc_clr ignored while memory is not ready.
            if (halt_req)  halt_pend_nxt = 1'b1;
            if (!mem_wait) state_nxt     = RUN;
         end

         default: begin
            state_nxt     = IDLE;
            tcounts_nxt   = 3'd0;
            halt_pend_nxt = 1'b0;
         end
      endcase
   end

   // State register, timing count, retire pulse and retired-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tcounts    <= 3'd0;
         halt_pend  <= 1'b0;
         instr_done <= 1'b0;
         instr_cnt  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state      <= state_nxt;
         tcounts    <= tcounts_nxt;
         halt_pend  <= halt_pend_nxt;
         instr_done <= retire;
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   // Gated T-state decoder: one-hot from tcounts while running, zero otherwise.
   always_comb begin
      running = (state != IDLE);
      T       = running ? (8'b1 << tcounts) : 8'h00;
   end

endmodule

// File: tb/tb_timing_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timing_sequencer
//   Scoreboard bench for timing_sequencer. The stimulus process drives inputs
//   on the falling edge, advances an instruction-level reference model and
//   queues the outputs expected after the next rising edge. A monitor process
//   pops and compares each entry shortly after that rising edge.
//   Build with SINGLE_STEP_EN defined to exercise the step port as well.
// ---------------------------------------------------------------------------
module tb_timing_sequencer;

   localparam int T_LAST = 7;
   localparam int CNT_W  = 8;   // narrow counter so the wrap is reached quickly

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             halt_req = 1'b0;
   logic             sc_clr = 1'b0;
   logic             mem_wait = 1'b0;
`ifdef SINGLE_STEP_EN
   logic             step = 1'b0;
`endif
   logic [2:0]       tcounts;
   logic [7:0]       T;
   logic             running;
   logic             instr_done;
   logic [CNT_W-1:0] instr_cnt;

   timing_sequencer #(.T_LAST(T_LAST), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .halt_req   (halt_req),
      .sc_clr     (sc_clr),
      .mem_wait   (mem_wait),
`ifdef SINGLE_STEP_EN
      .step       (step),
`endif
      .tcounts    (tcounts),
      .T          (T),
      .running    (running),
      .instr_done (instr_done),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   // Expected outputs after one rising edge.
   typedef struct {
      int tc;
      int tv;
      int run;
      int done;
      int cnt;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   // Reference model: an instruction in progress, its current T-step, whether
   // it is stalled on memory, whether a halt is pending, retired count.
   bit m_active, m_stalled, m_pend, m_done;
   int m_t, m_cnt;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_stalled = 1'b0;
      m_pend    = 1'b0;
      m_done    = 1'b0;
      m_t       = 0;
      m_cnt     = 0;
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge(input bit s, input bit h, input bit c, input bit w, input bit st);
      m_done = 1'b0;
      if (!m_active) begin
         m_t = 0;
         if (s) begin
            m_active = 1'b1;
            m_pend   = h;
         end else if (st) begin
            m_active = 1'b1;
            m_pend   = 1'b1;
         end
      end else begin
         if (h) m_pend = 1'b1;
         if (m_stalled) begin
            if (!w) m_stalled = 1'b0;
         end else if (c || (!w && m_t == T_LAST)) begin
            m_done = 1'b1;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_t    = 0;
            if (m_pend) begin
               m_active = 1'b0;
               m_pend   = 1'b0;
            end
         end else if (w) begin
            m_stalled = 1'b1;
         end else begin
            m_t = m_t + 1;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic cyc(input bit s, input bit h, input bit c, input bit w, input bit st);
      bit   st_eff;
      exp_t e;
      @(negedge clk);
      start    = s;
      halt_req = h;
      sc_clr   = c;
      mem_wait = w;
`ifdef SINGLE_STEP_EN
      step   = st;
      st_eff = st;
`else
      st_eff = 1'b0 & st;   // step port absent in this build
`endif
      model_edge(s, h, c, w, st_eff);
      e.tc   = m_t;
      e.tv   = m_active ? (1 << m_t) : 0;
      e.run  = int'(m_active);
      e.done = int'(m_done);
      e.cnt  = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Run free until the model reaches the given T-step in RUN (bounded).
   task automatic wait_t(input int target);
      int guard = 0;
      while (!(m_active && !m_stalled && m_t == target) && guard < 20) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      if (guard >= 20) begin
         checks++;
         failures++;
         $display("FAIL wait_t: T%0d not reached within 20 cycles", target);
      end
   endtask

   // Asynchronous reset between edges; outputs must clear immediately.
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      start    = 1'b0;
      halt_req = 1'b0;
      sc_clr   = 1'b0;
      mem_wait = 1'b0;
`ifdef SINGLE_STEP_EN
      step     = 1'b0;
`endif
      #1;
      check("rst_tcounts",    int'(tcounts),    0);
      check("rst_T",          int'(T),          0);
      check("rst_running",    int'(running),    0);
      check("rst_instr_done", int'(instr_done), 0);
      check("rst_instr_cnt",  int'(instr_cnt),  0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare every queued expectation just after its rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tcounts",    int'(tcounts),    e.tc);
            check("T",          int'(T),          e.tv);
            check("running",    int'(running),    e.run);
            check("instr_done", int'(instr_done), e.done);
            check("instr_cnt",  int'(instr_cnt),  e.cnt);
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      model_reset();
      #1;
      check("por_tcounts",   int'(tcounts),   0);
      check("por_T",         int'(T),         0);
      check("por_running",   int'(running),   0);
      check("por_instr_cnt", int'(instr_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // halt_req alone in IDLE is ignored.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);

      // Free run: one start cycle then 24 cycles, three retirements.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(24);

      // Early end of instruction at T3; start while running is ignored.
      wait_t(3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Memory stall at T2 for three cycles, sc_clr during the stall ignored.
      wait_t(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle_cycles(3);

      // Halt request at T1: runs to T7, retires, back to IDLE.
      wait_t(1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(10);

      // start and halt_req together in IDLE: exactly one instruction.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(10);

      // Asynchronous reset in the middle of an instruction at T5.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_t(5);
      do_reset();
      idle_cycles(2);

`ifdef SINGLE_STEP_EN
      // Single step: one full instruction then IDLE; step in RUN ignored.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(10);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(10);
      // start has priority over step: no pending halt, keeps running.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(2);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(12);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(2);
`endif

      // Counter wrap: retire every cycle until instr_cnt rolls over, then halt.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < (1 << CNT_W) + 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(3);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 9)  == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 5)  == 0,
                $urandom_range(0, 14) == 0);
         end
      end

      idle_cycles(2);
      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
